// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive sampler.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned MIN_PERIOD = 4;
    localparam int unsigned IDX_W      = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    // Clamp very short periods so the half-bit preload and the reload never collapse to zero.
    function automatic logic [31:0] eff_period(input logic [31:0] period);
        return (period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : period;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Flops reset to RESET_VAL so an idle-high line never shows a false edge at reset release.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= {N{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: mid-bit sampling FSM with a one-byte valid/ready output buffer.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err_o pulse; default is 8N1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              rx_i,
    input  logic [31:0]       bit_period_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err_o,
`endif
    output logic              busy_o
);

    logic rxs;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d_i     (rx_i),
        .q_o     (rxs)
    );

    state_e              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [31:0]         period_q, period_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                expiry;
    logic                stop_good;
    logic                stop_bad;

    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                frame_err_q;
    logic                overrun_q;

`ifdef UART_RX_PARITY_EN
    logic                par_bad_q, par_bad_d;
    logic                par_fail;
    logic                parity_err_q;
`endif

    assign expiry = (cnt_q == 32'd0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_fail  = 1'b0;
`endif

        if (state_q != IDLE) begin
            cnt_d = expiry ? (period_q - 32'd1) : (cnt_q - 32'd1);
        end

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    period_d = eff_period(bit_period_i);
                    cnt_d    = eff_period(bit_period_i) >> 1;
                    state_d  = START;
                end
            end
            START: begin
                bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (expiry) begin
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (expiry) begin
                    shift_d   = {rxs, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expiry) begin
                    par_fail  = (^shift_q) != rxs;
                    par_bad_d = par_fail;
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (expiry) begin
`ifdef UART_RX_PARITY_EN
                    stop_good = rxs && !par_bad_q;
`else
                    stop_good = rxs;
`endif
                    stop_bad  = !rxs;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= 32'(MIN_PERIOD);
            shift_q   <= '0;
            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // A delivery into a full buffer is dropped unless the consumer drains it on the same edge.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= 1'b0;
            if (stop_good) begin
                if (!valid_q || ready_i) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= par_fail;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: expected bytes queued at send time, popped on each transfer.
// Inputs change on the falling edge; outputs are observed 1 time unit after it.
module tb_uart_rx_sampler;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Rising edge (counted from the start-bit falling edge) at which the stop bit is judged, P=16.
    localparam int STOP_EDGE = 16 * (FRAME_BITS - 1) + 12;

    logic        clk = 1'b0;
    logic        arst_ni = 1'b0;
    logic        rx_i = 1'b1;
    logic        ready_i = 1'b1;
    logic [31:0] bit_period_i = 32'd16;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        busy_o;
`ifdef UART_RX_PARITY_EN
    logic        parity_err_o;
`endif

    always #5 clk = ~clk;

    uart_rx_sampler #(.SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .rx_i         (rx_i),
        .bit_period_i (bit_period_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .busy_o       (busy_o)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    int         n_perr  = 0;

    // Scoreboard monitor: every valid&&ready transfer must match the oldest queued byte.
    always begin
        @(negedge clk);
        #1;
        if (arst_ni) begin
            if (valid_o)     n_valid++;
            if (frame_err_o) n_ferr++;
            if (overrun_o)   n_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err_o) n_perr++;
`endif
            if (valid_o && ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_byte: got %02h, none expected", data_o);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (data_o !== exp_b) begin
                        n_errors++;
                        $display("FAIL rx_byte: got %02h expected %02h", data_o, exp_b);
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b, input int p);
        rx_i = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int p);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
`ifdef UART_RX_PARITY_EN
        drive_bit(par, p);
`else
        if (par) rx_i = 1'b1;
`endif
        drive_bit(stop, p);
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        arst_ni = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({data_o, valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_state: got data=%02h v=%b fe=%b ov=%b busy=%b expected all 0",
                     data_o, valid_o, frame_err_o, overrun_o, busy_o);
        end
        @(negedge clk);
        arst_ni = 1'b1;
        idle(4);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pats [4] = '{8'h55, 8'h00, 8'hFF, 8'h81};
        int v0;
        ready_i = 1'b1;
        foreach (pats[k]) begin
            v0 = n_valid;
            exp_q.push_back(pats[k]);
            send_frame(pats[k], ^pats[k], 1'b1, 16);
            idle(8);
            n_checks++;
            if (n_valid - v0 != 1) begin
                n_errors++;
                $display("FAIL valid_width_%02h: got %0d cycles expected 1", pats[k], n_valid - v0);
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL basic_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int v0 = n_valid;
        int f0 = n_ferr;
        rx_i = 1'b0;
        repeat (5) @(negedge clk);
        rx_i = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_busy_before_expiry: got %b expected 1", busy_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch_busy_after_expiry: got %b expected 0", busy_o);
        end
        idle(40);
        n_checks++;
        if ((n_valid - v0) != 0 || (n_ferr - f0) != 0) begin
            n_errors++;
            $display("FAIL glitch_no_output: got valid=%0d ferr=%0d expected 0 0", n_valid - v0, n_ferr - f0);
        end
    endtask

    task automatic test_frame_err();
        int v0 = n_valid;
        int f0 = n_ferr;
        send_frame(8'hA3, ^8'hA3, 1'b0, 16);
        idle(48);
        n_checks++;
        if (n_ferr - f0 != 1) begin
            n_errors++;
            $display("FAIL frame_err_pulses: got %0d expected 1", n_ferr - f0);
        end
        n_checks++;
        if ((n_valid - v0) != 0 || valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_err_valid: got %0d cycles (valid_o=%b) expected 0", n_valid - v0, valid_o);
        end
    endtask

    task automatic test_overrun();
        int o0 = n_ovr;
        ready_i = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, ^8'hA5, 1'b1, 16);
        idle(4);
        send_frame(8'h3C, ^8'h3C, 1'b1, 16);
        idle(8);
        n_checks++;
        if (data_o !== 8'hA5 || valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_hold: got data=%02h v=%b expected A5 1", data_o, valid_o);
        end
        n_checks++;
        if (n_ovr - o0 != 1) begin
            n_errors++;
            $display("FAIL overrun_pulses: got %0d expected 1", n_ovr - o0);
        end
        ready_i = 1'b1;
        idle(4);
        n_checks++;
        if (valid_o !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL overrun_drain: got v=%b pending=%0d expected 0 0", valid_o, exp_q.size());
        end
    endtask

    task automatic test_accept_on_deliver();
        int o0 = n_ovr;
        ready_i = 1'b0;
        exp_q.push_back(8'h96);
        send_frame(8'h96, ^8'h96, 1'b1, 16);
        idle(4);
        exp_q.push_back(8'h69);
        fork
            send_frame(8'h69, ^8'h69, 1'b1, 16);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                ready_i = 1'b1;
                @(negedge clk);
                ready_i = 1'b0;
            end
        join
        idle(4);
        n_checks++;
        if (data_o !== 8'h69 || valid_o !== 1'b1 || (n_ovr - o0) != 0) begin
            n_errors++;
            $display("FAIL accept_on_deliver: got data=%02h v=%b ovr=%0d expected 69 1 0",
                     data_o, valid_o, n_ovr - o0);
        end
        ready_i = 1'b1;
        idle(4);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL accept_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [3] = '{8'h12, 8'hED, 8'h7E};
        int f0 = n_ferr;
        ready_i = 1'b1;
        foreach (pats[k]) begin
            exp_q.push_back(pats[k]);
            send_frame(pats[k], ^pats[k], 1'b1, 16);
        end
        idle(40);
        n_checks++;
        if (exp_q.size() != 0 || (n_ferr - f0) != 0) begin
            n_errors++;
            $display("FAIL back_to_back: got pending=%0d ferr=%0d expected 0 0", exp_q.size(), n_ferr - f0);
        end
    endtask

    task automatic test_period_latch();
        exp_q.push_back(8'h3A);
        fork
            send_frame(8'h3A, ^8'h3A, 1'b1, 16);
            begin
                repeat (20) @(negedge clk);
                bit_period_i = 32'd5;
            end
        join
        bit_period_i = 32'd16;
        idle(40);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL period_latch: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_min_period();
        bit_period_i = 32'd2;
        exp_q.push_back(8'hC6);
        send_frame(8'hC6, ^8'hC6, 1'b1, 4);
        idle(12);
        bit_period_i = 32'd16;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL min_period: got %0d pending expected 0", exp_q.size());
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0 = n_valid;
        int p0 = n_perr;
        send_frame(8'h07, 1'b0, 1'b1, 16);
        idle(40);
        n_checks++;
        if ((n_perr - p0) != 1 || (n_valid - v0) != 0) begin
            n_errors++;
            $display("FAIL parity_bad: got perr=%0d valid=%0d expected 1 0", n_perr - p0, n_valid - v0);
        end
        p0 = n_perr;
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 16);
        idle(40);
        n_checks++;
        if ((n_perr - p0) != 0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL parity_good: got perr=%0d pending=%0d expected 0 0", n_perr - p0, exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_midframe();
        int v0 = n_valid;
        bit_period_i = 32'd8680;
        drive_bit(1'b0, 8680);
        drive_bit(1'b1, 3 * 8680 + 4340);
        #1;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL midframe_busy: got %b expected 1", busy_o);
        end
        @(negedge clk);
        arst_ni = 1'b0;
        rx_i = 1'b0;
        bit_period_i = 32'd16;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00) begin
            n_errors++;
            $display("FAIL midframe_reset: got busy=%b v=%b data=%02h expected 0 0 00", busy_o, valid_o, data_o);
        end
        @(negedge clk);
        arst_ni = 1'b1;
        exp_q.push_back(8'h12);
        send_frame(8'h12, ^8'h12, 1'b1, 16);
        idle(12);
        n_checks++;
        if ((n_valid - v0) != 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL after_reset_frame: got valid=%0d pending=%0d expected 1 0", n_valid - v0, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_accept_on_deliver();
        test_back_to_back();
        test_period_latch();
        test_min_period();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
